// File: rtl/out_buff_pkg.sv
// ============================================================================
// Module   : out_buff_pkg
// Purpose  : Shared sizes and types for the 8-to-32 lane widening buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package out_buff_pkg;
    localparam int DW        = 32;
    localparam int LANES_IN  = 8;
    localparam int LANES_OUT = 32;
    localparam int BEATS     = LANES_OUT / LANES_IN;
    localparam int CNT_W     = $clog2(BEATS);

    typedef logic [DW-1:0]    lane_t;
    typedef logic [CNT_W-1:0] cnt_t;
endpackage

`default_nettype wire

// File: rtl/out_buff_ctrl.sv
// ============================================================================
// Module   : out_buff_ctrl
// Purpose  : Beat counter, lane-bank write select and frame emit decision.
//            Optional partial-frame flush under OUT_BUFF_FLUSH_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_buff_ctrl
    import out_buff_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             acc_i,
`ifdef OUT_BUFF_FLUSH_EN
    input  logic             flush_i,
`endif
    output logic [BEATS-1:0] wr_sel_o,
    output logic             emit_o,
    output logic             clr_asm_o,
    output logic             busy_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic w_last;
    logic w_flush;

    always_comb begin
        w_last = (cnt_q == cnt_t'(BEATS - 1));
`ifdef OUT_BUFF_FLUSH_EN
        // A flush only matters when there is something to emit.
        w_flush = flush_i & (acc_i | (cnt_q != '0));
`else
        w_flush = 1'b0;
`endif
        emit_o    = (acc_i & w_last) | w_flush;
        clr_asm_o = emit_o;
        busy_o    = (cnt_q != '0);

        cnt_d = cnt_q;
        if (emit_o) begin
            cnt_d = '0;
        end else if (acc_i) begin
            cnt_d = cnt_q + cnt_t'(1);
        end

        wr_sel_o = '0;
        for (int b = 0; b < BEATS; b++) begin
            wr_sel_o[b] = acc_i & (cnt_q == cnt_t'(b));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/out_buff.sv
// ============================================================================
// Module   : out_buff
// Purpose  : Packs four 8-lane beats into one registered 32-lane frame with a
//            one-cycle valid pulse. Define OUT_BUFF_FLUSH_EN for the flush port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_buff
    import out_buff_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
`ifdef OUT_BUFF_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          enable,
    input  logic [DW-1:0] in_data_0,
    input  logic [DW-1:0] in_data_1,
    input  logic [DW-1:0] in_data_2,
    input  logic [DW-1:0] in_data_3,
    input  logic [DW-1:0] in_data_4,
    input  logic [DW-1:0] in_data_5,
    input  logic [DW-1:0] in_data_6,
    input  logic [DW-1:0] in_data_7,
    input  logic          in_data_valid,
    output logic [DW-1:0] out_data_0,  output logic [DW-1:0] out_data_1,
    output logic [DW-1:0] out_data_2,  output logic [DW-1:0] out_data_3,
    output logic [DW-1:0] out_data_4,  output logic [DW-1:0] out_data_5,
    output logic [DW-1:0] out_data_6,  output logic [DW-1:0] out_data_7,
    output logic [DW-1:0] out_data_8,  output logic [DW-1:0] out_data_9,
    output logic [DW-1:0] out_data_10, output logic [DW-1:0] out_data_11,
    output logic [DW-1:0] out_data_12, output logic [DW-1:0] out_data_13,
    output logic [DW-1:0] out_data_14, output logic [DW-1:0] out_data_15,
    output logic [DW-1:0] out_data_16, output logic [DW-1:0] out_data_17,
    output logic [DW-1:0] out_data_18, output logic [DW-1:0] out_data_19,
    output logic [DW-1:0] out_data_20, output logic [DW-1:0] out_data_21,
    output logic [DW-1:0] out_data_22, output logic [DW-1:0] out_data_23,
    output logic [DW-1:0] out_data_24, output logic [DW-1:0] out_data_25,
    output logic [DW-1:0] out_data_26, output logic [DW-1:0] out_data_27,
    output logic [DW-1:0] out_data_28, output logic [DW-1:0] out_data_29,
    output logic [DW-1:0] out_data_30, output logic [DW-1:0] out_data_31,
    output logic          out_data_valid,
    output logic          busy
);

    logic                        w_acc;
    logic [BEATS-1:0]            w_wr_sel;
    logic                        w_emit;
    logic                        w_clr_asm;
    lane_t [LANES_IN-1:0]        w_beat;
    lane_t [LANES_OUT-1:0]       w_frame;
    lane_t [LANES_OUT-1:0]       asm_q;
    lane_t [LANES_OUT-1:0]       asm_d;
    lane_t [LANES_OUT-1:0]       out_q;
    logic                        valid_q;

    assign w_acc  = enable & in_data_valid;
    assign w_beat = {in_data_7, in_data_6, in_data_5, in_data_4,
                     in_data_3, in_data_2, in_data_1, in_data_0};

    out_buff_ctrl u_ctrl (
        .clk       (clk),
        .rst       (rst),
        .acc_i     (w_acc),
`ifdef OUT_BUFF_FLUSH_EN
        .flush_i   (flush),
`endif
        .wr_sel_o  (w_wr_sel),
        .emit_o    (w_emit),
        .clr_asm_o (w_clr_asm),
        .busy_o    (busy)
    );

    // The incoming beat is merged here so a completing beat reaches the output
    // registers on the same edge it is accepted.
    always_comb begin
        w_frame = asm_q;
        for (int b = 0; b < BEATS; b++) begin
            if (w_wr_sel[b]) begin
                w_frame[b*LANES_IN +: LANES_IN] = w_beat;
            end
        end
        asm_d = w_clr_asm ? '0 : w_frame;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            asm_q   <= asm_d;
            valid_q <= w_emit;
            if (w_emit) begin
                out_q <= w_frame;
            end
        end
    end

    assign out_data_valid = valid_q;

    assign out_data_0  = out_q[0];  assign out_data_1  = out_q[1];
    assign out_data_2  = out_q[2];  assign out_data_3  = out_q[3];
    assign out_data_4  = out_q[4];  assign out_data_5  = out_q[5];
    assign out_data_6  = out_q[6];  assign out_data_7  = out_q[7];
    assign out_data_8  = out_q[8];  assign out_data_9  = out_q[9];
    assign out_data_10 = out_q[10]; assign out_data_11 = out_q[11];
    assign out_data_12 = out_q[12]; assign out_data_13 = out_q[13];
    assign out_data_14 = out_q[14]; assign out_data_15 = out_q[15];
    assign out_data_16 = out_q[16]; assign out_data_17 = out_q[17];
    assign out_data_18 = out_q[18]; assign out_data_19 = out_q[19];
    assign out_data_20 = out_q[20]; assign out_data_21 = out_q[21];
    assign out_data_22 = out_q[22]; assign out_data_23 = out_q[23];
    assign out_data_24 = out_q[24]; assign out_data_25 = out_q[25];
    assign out_data_26 = out_q[26]; assign out_data_27 = out_q[27];
    assign out_data_28 = out_q[28]; assign out_data_29 = out_q[29];
    assign out_data_30 = out_q[30]; assign out_data_31 = out_q[31];

endmodule

`default_nettype wire

// File: tb/tb_out_buff.sv
// ============================================================================
// Module   : tb_out_buff
// Purpose  : Directed self-checking bench for out_buff (flush cases when
//            OUT_BUFF_FLUSH_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_buff;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        in_data_valid;
    logic [31:0] tb_in  [8];
    logic [31:0] tb_out [32];
    logic        out_data_valid;
    logic        busy;
`ifdef OUT_BUFF_FLUSH_EN
    logic        flush;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ebase [4];

    always #5 clk = ~clk;

    out_buff dut (
        .clk            (clk),
        .rst            (rst),
`ifdef OUT_BUFF_FLUSH_EN
        .flush          (flush),
`endif
        .enable         (enable),
        .in_data_0      (tb_in[0]), .in_data_1 (tb_in[1]),
        .in_data_2      (tb_in[2]), .in_data_3 (tb_in[3]),
        .in_data_4      (tb_in[4]), .in_data_5 (tb_in[5]),
        .in_data_6      (tb_in[6]), .in_data_7 (tb_in[7]),
        .in_data_valid  (in_data_valid),
        .out_data_0  (tb_out[0]),  .out_data_1  (tb_out[1]),
        .out_data_2  (tb_out[2]),  .out_data_3  (tb_out[3]),
        .out_data_4  (tb_out[4]),  .out_data_5  (tb_out[5]),
        .out_data_6  (tb_out[6]),  .out_data_7  (tb_out[7]),
        .out_data_8  (tb_out[8]),  .out_data_9  (tb_out[9]),
        .out_data_10 (tb_out[10]), .out_data_11 (tb_out[11]),
        .out_data_12 (tb_out[12]), .out_data_13 (tb_out[13]),
        .out_data_14 (tb_out[14]), .out_data_15 (tb_out[15]),
        .out_data_16 (tb_out[16]), .out_data_17 (tb_out[17]),
        .out_data_18 (tb_out[18]), .out_data_19 (tb_out[19]),
        .out_data_20 (tb_out[20]), .out_data_21 (tb_out[21]),
        .out_data_22 (tb_out[22]), .out_data_23 (tb_out[23]),
        .out_data_24 (tb_out[24]), .out_data_25 (tb_out[25]),
        .out_data_26 (tb_out[26]), .out_data_27 (tb_out[27]),
        .out_data_28 (tb_out[28]), .out_data_29 (tb_out[29]),
        .out_data_30 (tb_out[30]), .out_data_31 (tb_out[31]),
        .out_data_valid (out_data_valid),
        .busy           (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat (lane i = base + i) for a single edge.
    task automatic beat(input logic [31:0] base, input logic en);
        for (int i = 0; i < 8; i++) tb_in[i] = base + 32'(i);
        in_data_valid = 1'b1;
        enable        = en;
        tick();
        in_data_valid = 1'b0;
        enable        = 1'b1;
    endtask

    // Lanes of beats below nb come from ebase; the rest must read zero.
    task automatic check_frame(input string tag, input int nb);
        for (int k = 0; k < 32; k++) begin
            check_val($sformatf("%s lane%0d", tag, k), tb_out[k],
                      ((k / 8) < nb) ? ebase[k / 8] + 32'(k % 8) : 32'h0);
        end
    endtask

    initial begin
        rst           = 1'b1;
        enable        = 1'b0;
        in_data_valid = 1'b0;
`ifdef OUT_BUFF_FLUSH_EN
        flush         = 1'b0;
`endif
        for (int i = 0; i < 8; i++) tb_in[i] = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        check_val("rst valid", {31'h0, out_data_valid}, 32'h0);
        check_val("rst busy", {31'h0, busy}, 32'h0);
        check_val("rst out0", tb_out[0], 32'h0);
        check_val("rst out31", tb_out[31], 32'h0);

        // Basic frame.
        beat(32'h000, 1'b1);
        check_val("t1 busy b1", {31'h0, busy}, 32'h1);
        check_val("t1 valid b1", {31'h0, out_data_valid}, 32'h0);
        beat(32'h100, 1'b1);
        check_val("t1 busy b2", {31'h0, busy}, 32'h1);
        beat(32'h200, 1'b1);
        check_val("t1 busy b3", {31'h0, busy}, 32'h1);
        check_val("t1 valid b3", {31'h0, out_data_valid}, 32'h0);
        beat(32'h300, 1'b1);
        check_val("t1 valid", {31'h0, out_data_valid}, 32'h1);
        check_val("t1 busy end", {31'h0, busy}, 32'h0);
        ebase[0] = 32'h000; ebase[1] = 32'h100; ebase[2] = 32'h200; ebase[3] = 32'h300;
        check_frame("t1", 4);
        tick();
        check_val("t1 pulse width", {31'h0, out_data_valid}, 32'h0);
        check_val("t1 hold", tb_out[9], 32'h101);

        // Back-to-back frames.
        for (int b = 0; b < 8; b++) begin
            beat(32'h1000 + 32'(b) * 32'h100, 1'b1);
            check_val($sformatf("t2 valid b%0d", b), {31'h0, out_data_valid},
                      (b == 3 || b == 7) ? 32'h1 : 32'h0);
            if (b == 3) begin
                ebase[0] = 32'h1000; ebase[1] = 32'h1100; ebase[2] = 32'h1200; ebase[3] = 32'h1300;
                check_frame("t2 f0", 4);
            end
            if (b >= 4 && b <= 6) begin
                check_val($sformatf("t2 stable0 b%0d", b), tb_out[0], 32'h1000);
                check_val($sformatf("t2 stable31 b%0d", b), tb_out[31], 32'h1307);
            end
        end
        ebase[0] = 32'h1400; ebase[1] = 32'h1500; ebase[2] = 32'h1600; ebase[3] = 32'h1700;
        check_frame("t2 f1", 4);

        // Beat dropped by enable=0.
        beat(32'h2000, 1'b1);
        beat(32'h2100, 1'b0);
        check_val("t3 busy", {31'h0, busy}, 32'h1);
        beat(32'h2200, 1'b1);
        beat(32'h2300, 1'b1);
        check_val("t3 valid early", {31'h0, out_data_valid}, 32'h0);
        beat(32'h2400, 1'b1);
        check_val("t3 valid", {31'h0, out_data_valid}, 32'h1);
        ebase[0] = 32'h2000; ebase[1] = 32'h2200; ebase[2] = 32'h2300; ebase[3] = 32'h2400;
        check_frame("t3", 4);

        // Mid-frame reset discards the partial frame.
        beat(32'h3000, 1'b1);
        beat(32'h3100, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t4 valid", {31'h0, out_data_valid}, 32'h0);
        check_val("t4 busy", {31'h0, busy}, 32'h0);
        check_val("t4 out0", tb_out[0], 32'h0);
        check_val("t4 out31", tb_out[31], 32'h0);
        for (int b = 0; b < 3; b++) begin
            beat(32'h3200 + 32'(b) * 32'h100, 1'b1);
            check_val($sformatf("t4 valid b%0d", b), {31'h0, out_data_valid}, 32'h0);
            check_val($sformatf("t4 out0 b%0d", b), tb_out[0], 32'h0);
        end
        beat(32'h3500, 1'b1);
        check_val("t4 valid end", {31'h0, out_data_valid}, 32'h1);
        ebase[0] = 32'h3200; ebase[1] = 32'h3300; ebase[2] = 32'h3400; ebase[3] = 32'h3500;
        check_frame("t4", 4);

        // Reset on the completing edge wins.
        beat(32'h4000, 1'b1);
        beat(32'h4100, 1'b1);
        beat(32'h4200, 1'b1);
        rst = 1'b1;
        beat(32'h4300, 1'b1);
        rst = 1'b0;
        check_val("t5 valid", {31'h0, out_data_valid}, 32'h0);
        check_val("t5 busy", {31'h0, busy}, 32'h0);
        check_val("t5 out8", tb_out[8], 32'h0);
        tick();
        check_val("t5 valid later", {31'h0, out_data_valid}, 32'h0);

`ifdef OUT_BUFF_FLUSH_EN
        // Flush of a three-beat partial frame.
        beat(32'hA000_0000, 1'b1);
        beat(32'hB000_0000, 1'b1);
        beat(32'hC000_0000, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("f1 valid", {31'h0, out_data_valid}, 32'h1);
        check_val("f1 busy", {31'h0, busy}, 32'h0);
        ebase[0] = 32'hA000_0000; ebase[1] = 32'hB000_0000; ebase[2] = 32'hC000_0000;
        check_frame("f1", 3);
        tick();
        check_val("f1 pulse width", {31'h0, out_data_valid}, 32'h0);

        // Flush coinciding with the completing beat: one pulse only.
        beat(32'hD000_0000, 1'b1);
        beat(32'hE000_0000, 1'b1);
        beat(32'hF000_0000, 1'b1);
        flush = 1'b1;
        beat(32'h9000_0000, 1'b1);
        flush = 1'b0;
        check_val("f2 valid", {31'h0, out_data_valid}, 32'h1);
        ebase[0] = 32'hD000_0000; ebase[1] = 32'hE000_0000;
        ebase[2] = 32'hF000_0000; ebase[3] = 32'h9000_0000;
        check_frame("f2", 4);
        tick();
        check_val("f2 single pulse", {31'h0, out_data_valid}, 32'h0);

        // Flush with nothing held does nothing.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_val("f3 valid", {31'h0, out_data_valid}, 32'h0);
        check_val("f3 busy", {31'h0, busy}, 32'h0);
        check_val("f3 hold", tb_out[24], 32'h9000_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
